// File: rtl/funrv32_pkg.sv
// Shared types and constants for the funRV32 writeback slice.
// Load funct3 encodings and the round-robin preference state encoding.
package funrv32_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef enum logic {
      PREF_LD = 1'b0,
      PREF_EX = 1'b1
   } pref_e;

endpackage

// File: rtl/funrv32_writeback_if.sv
// Producer/regfile bundle for the writeback stage; slave = writeback stage, master = environment.
// Valid/ready per producer; ready is combinational from the stage and a transfer is valid&ready at posedge.
interface funrv32_writeback_if;
   import funrv32_pkg::*;

   logic            ex_valid;
   logic            ex_ready;
   logic [AW-1:0]   ex_ad;
   logic [XLEN-1:0] ex_data;

   logic            ld_valid;
   logic            ld_ready;
   logic [AW-1:0]   ld_ad;
   logic [XLEN-1:0] ld_word;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_addr_lo;

   logic            kill;

   logic            rf_we;
   logic [AW-1:0]   rf_ad;
   logic [XLEN-1:0] rf_rd;
   logic            ld_err;

   modport slave (
      input  ex_valid, ex_ad, ex_data,
      input  ld_valid, ld_ad, ld_word, ld_funct3, ld_addr_lo,
      input  kill,
      output ex_ready, ld_ready,
      output rf_we, rf_ad, rf_rd, ld_err
   );

   modport master (
      output ex_valid, ex_ad, ex_data,
      output ld_valid, ld_ad, ld_word, ld_funct3, ld_addr_lo,
      output kill,
      input  ex_ready, ld_ready,
      input  rf_we, rf_ad, rf_rd, ld_err
   );

endinterface

// File: rtl/funrv32_load_align.sv
// Load data extraction and sign/zero extension, plus misaligned/illegal funct3 detection.
// Purely combinational, zero latency, no backpressure.
module funrv32_load_align
   import funrv32_pkg::*;
(
   input  logic [XLEN-1:0] i_word,
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   output logic [XLEN-1:0] o_data,
   output logic            o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
   end

   assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_data = '0;
      o_err  = 1'b0;
      case (i_funct3)
         LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  o_data = {24'd0, w_byte};
         LD_LH: begin
            o_data = {{16{w_half[15]}}, w_half};
            o_err  = i_addr_lo[0];
         end
         LD_LHU: begin
            o_data = {16'd0, w_half};
            o_err  = i_addr_lo[0];
         end
         LD_LW: begin
            o_data = i_word;
            o_err  = |i_addr_lo;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/funrv32_writeback.sv
// Writeback stage: round-robin arbitration of execute/load results into a registered regfile write (latency 1).
// Ready is combinational from grant; kill/reset deassert both readies. Optional FUNRV32_WB_RETIRE_CNT_EN adds a retire counter.
module funrv32_writeback
   import funrv32_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetb,
   funrv32_writeback_if.slave   io_wb
`ifdef FUNRV32_WB_RETIRE_CNT_EN
   ,
   output logic [63:0]          o_wb_retired
`endif
);

   pref_e           r_pref;
   pref_e           w_pref_nxt;
   logic            w_grant_ex;
   logic            w_grant_ld;
   logic [XLEN-1:0] w_ld_data;
   logic            w_ld_err;

   logic            r_rf_we;
   logic [AW-1:0]   r_rf_ad;
   logic [XLEN-1:0] r_rf_rd;
   logic            r_ld_err;

   funrv32_load_align u_align (
      .i_word    (io_wb.ld_word),
      .i_funct3  (io_wb.ld_funct3),
      .i_addr_lo (io_wb.ld_addr_lo),
      .o_data    (w_ld_data),
      .o_err     (w_ld_err)
   );

   always_ff @(posedge clk) begin
      if (!resetb) r_pref <= PREF_LD;
      else         r_pref <= w_pref_nxt;
   end

   // Preference always points at the source that did not win last.
   always_comb begin
      w_grant_ex = 1'b0;
      w_grant_ld = 1'b0;
      w_pref_nxt = r_pref;
      if (resetb && !io_wb.kill) begin
         if (io_wb.ex_valid && io_wb.ld_valid) begin
            w_grant_ld = (r_pref == PREF_LD);
            w_grant_ex = (r_pref == PREF_EX);
         end else begin
            w_grant_ex = io_wb.ex_valid;
            w_grant_ld = io_wb.ld_valid;
         end
         if (w_grant_ld) w_pref_nxt = PREF_EX;
         if (w_grant_ex) w_pref_nxt = PREF_LD;
      end
   end

   assign io_wb.ex_ready = w_grant_ex;
   assign io_wb.ld_ready = w_grant_ld;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         r_rf_we  <= 1'b0;
         r_rf_ad  <= '0;
         r_rf_rd  <= '0;
         r_ld_err <= 1'b0;
      end else begin
         r_rf_we  <= 1'b0;
         r_ld_err <= 1'b0;
         if (w_grant_ex) begin
            r_rf_we <= |io_wb.ex_ad;
            r_rf_ad <= io_wb.ex_ad;
            r_rf_rd <= io_wb.ex_data;
         end else if (w_grant_ld) begin
            r_rf_we  <= !w_ld_err && (|io_wb.ld_ad);
            r_rf_ad  <= io_wb.ld_ad;
            r_rf_rd  <= w_ld_data;
            r_ld_err <= w_ld_err;
         end
      end
   end

   assign io_wb.rf_we  = r_rf_we;
   assign io_wb.rf_ad  = r_rf_ad;
   assign io_wb.rf_rd  = r_rf_rd;
   assign io_wb.ld_err = r_ld_err;

`ifdef FUNRV32_WB_RETIRE_CNT_EN
   logic [63:0] r_retired;

   always_ff @(posedge clk) begin
      if (!resetb)      r_retired <= '0;
      else if (r_rf_we) r_retired <= r_retired + 64'd1;
   end

   assign o_wb_retired = r_retired;
`endif

endmodule
